// File: rtl/bp_pkg.sv
// bp_pkg - shared types and constants for the branch predictor.
//   bp_kind_t   : control-flow class reported by execute and stored per BTB entry.
//   bp_entry_t  : one BTB entry. The tag and counter fields are sized for the
//                 largest legal configuration. The top module zero-extends into
//                 them, so the unused upper bits stay constant.
//   ctr_*()     : saturating counter reset/allocate/limit values for a given width.
package bp_pkg;

    typedef enum logic [1:0] {
        COND = 2'd0,
        JUMP = 2'd1,
        CALL = 2'd2,
        RET  = 2'd3
    } bp_kind_t;

    localparam int TAG_MAX = 28;  // ENTRIES=4 leaves 28 PC bits above the index
    localparam int CTR_MAX = 4;

    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        bp_kind_t           kind;
        logic [29:0]        target;  // word address, PC[31:2]
        logic [CTR_MAX-1:0] ctr;
    } bp_entry_t;

    // Weakly not taken: reset value of every counter.
    function automatic logic [CTR_MAX-1:0] ctr_weak_nt(input int bits);
        return CTR_MAX'((1 << (bits - 1)) - 1);
    endfunction

    // Weakly taken: value written on allocation.
    function automatic logic [CTR_MAX-1:0] ctr_weak_t(input int bits);
        return CTR_MAX'(1 << (bits - 1));
    endfunction

    // Saturation ceiling.
    function automatic logic [CTR_MAX-1:0] ctr_top(input int bits);
        return CTR_MAX'((1 << bits) - 1);
    endfunction

endpackage

// File: rtl/bp_ras.sv
// bp_ras - circular return address stack.
//   clk_in, rst_in        : clock, asynchronous active-high reset
//   push, push_data       : push a return word address (PC[31:2])
//   pop                   : pop. This is a no-op when the stack is empty.
//   load, load_*          : overwrite the whole state (pointer, count, storage).
//                           load wins over push/pop in the same cycle.
//   nxt_ptr/cnt/mem       : the state this instance will hold after the edge,
//                           excluding load. Another copy can use these to load
//                           this stack together with its current push/pop.
//   top_out, empty_out    : top of stack (byte address), stack empty
// A push onto a full stack overwrites the oldest slot, and the count saturates.
module bp_ras
    import bp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        push,
    input  logic [29:0]                 push_data,
    input  logic                        pop,
    input  logic                        load,
    input  logic [PTR_W-1:0]            load_ptr,
    input  logic [PTR_W:0]              load_cnt,
    input  logic [DEPTH-1:0][29:0]      load_mem,
    output logic [PTR_W-1:0]            nxt_ptr,
    output logic [PTR_W:0]              nxt_cnt,
    output logic [DEPTH-1:0][29:0]      nxt_mem,
    output logic [31:0]                 top_out,
    output logic                        empty_out
);

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0][29:0] mem;
    logic [PTR_W-1:0]       ptr;      // next free slot
    logic [PTR_W:0]         cnt;
    logic [PTR_W-1:0]       top_idx;

    // Push and pop are never requested together: one lookup or update has one kind.
    always_comb begin
        nxt_mem = mem;
        nxt_ptr = ptr;
        nxt_cnt = cnt;
        if (push) begin
            nxt_mem[ptr] = push_data;
            nxt_ptr      = ptr + 1'b1;   // power-of-two depth wraps naturally
            if (cnt != FULL)
                nxt_cnt = cnt + 1'b1;
        end else if (pop && cnt != '0) begin
            nxt_ptr = ptr - 1'b1;
            nxt_cnt = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem <= '0;
            ptr <= '0;
            cnt <= '0;
        end else if (load) begin
            mem <= load_mem;
            ptr <= load_ptr;
            cnt <= load_cnt;
        end else begin
            mem <= nxt_mem;
            ptr <= nxt_ptr;
            cnt <= nxt_cnt;
        end
    end

    assign top_idx   = ptr - 1'b1;
    assign top_out   = {mem[top_idx], 2'b00};
    assign empty_out = (cnt == '0);

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor - direct-mapped BTB with saturating counters. It has an
// optional return address stack.
// Optional feature macro: BP_RAS_EN. When defined, speculative and architectural
// RAS copies are built and RET predicts the RAS top. When undefined, RET behaves
// like JUMP.
// Ports:
//   clk_in, rst_in            : clock, asynchronous active-high reset
//   lookup_valid_in, pc_in    : fetch query. lookup_valid_in gates speculative RAS activity.
//   pred_taken_out, pred_target_out, hit_out : combinational prediction for pc_in
//   upd_valid_in, upd_pc_in, upd_kind_in, upd_taken_in, upd_target_in :
//                               resolved control-flow instruction from execute
//   upd_mispredict_in         : flush. The speculative RAS reloads from the architectural RAS.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES   = 64,
    parameter int CTR_BITS  = 2,
    parameter int TAG_BITS  = 10,
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        lookup_valid_in,
    input  logic [31:0] pc_in,
    output logic        pred_taken_out,
    output logic [31:0] pred_target_out,
    output logic        hit_out,
    input  logic        upd_valid_in,
    input  logic [31:0] upd_pc_in,
    input  logic [1:0]  upd_kind_in,
    input  logic        upd_taken_in,
    input  logic [31:0] upd_target_in,
    input  logic        upd_mispredict_in
);

    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [CTR_MAX-1:0] CTR_NT  = ctr_weak_nt(CTR_BITS);
    localparam logic [CTR_MAX-1:0] CTR_T   = ctr_weak_t(CTR_BITS);
    localparam logic [CTR_MAX-1:0] CTR_TOP = ctr_top(CTR_BITS);

    localparam bp_entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, kind: COND,
                                        target: '0, ctr: CTR_NT};

    // Flop storage, because the lookup path is combinational.
    bp_entry_t btb [ENTRIES];

    logic [IDX_W-1:0]    lk_idx, up_idx;
    logic [TAG_BITS-1:0] lk_tag, up_tag;
    bp_entry_t           lk_ent, up_ent, wr_ent;
    logic                lk_hit, up_hit, wr_en;
    bp_kind_t            up_kind;
    logic [31:0]         seq_pc;
    logic [31:0]         ras_top;
    logic                ras_empty;

    assign lk_idx  = pc_in[IDX_W+1:2];
    assign lk_tag  = pc_in[IDX_W+2 +: TAG_BITS];
    assign up_idx  = upd_pc_in[IDX_W+1:2];
    assign up_tag  = upd_pc_in[IDX_W+2 +: TAG_BITS];
    assign up_kind = bp_kind_t'(upd_kind_in);

    assign lk_ent = btb[lk_idx];
    assign up_ent = btb[up_idx];
    assign lk_hit = lk_ent.valid && (lk_ent.tag == TAG_MAX'(lk_tag));
    assign up_hit = up_ent.valid && (up_ent.tag == TAG_MAX'(up_tag));
    assign seq_pc = pc_in + 32'd4;

    // ---------------- lookup ----------------
    always_comb begin
        hit_out         = 1'b0;
        pred_taken_out  = 1'b0;
        pred_target_out = seq_pc;
        if (!rst_in && lk_hit) begin
            hit_out = 1'b1;
            case (lk_ent.kind)
                COND:      pred_taken_out = lk_ent.ctr[CTR_BITS-1];
                JUMP, CALL,
                RET:       pred_taken_out = 1'b1;
                default:   pred_taken_out = 1'b0;
            endcase
            if (pred_taken_out)
                pred_target_out = {lk_ent.target, 2'b00};
            // An empty stack falls back to the target learnt at resolve time.
            if (lk_ent.kind == RET && !ras_empty)
                pred_target_out = ras_top;
        end
    end

    // ---------------- training ----------------
    always_comb begin
        wr_en  = 1'b0;
        wr_ent = up_ent;
        if (upd_valid_in) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (up_kind == COND) begin
                    if (upd_taken_in) begin
                        if (up_ent.ctr != CTR_TOP)
                            wr_ent.ctr = up_ent.ctr + 1'b1;
                    end else if (up_ent.ctr != '0) begin
                        wr_ent.ctr = up_ent.ctr - 1'b1;
                    end
                end
                if (upd_taken_in) begin
                    wr_ent.kind   = up_kind;
                    wr_ent.target = upd_target_in[31:2];
                end
            end else if (upd_taken_in) begin
                // Direct-mapped: the new branch simply evicts whatever aliases here.
                wr_en         = 1'b1;
                wr_ent.valid  = 1'b1;
                wr_ent.tag    = TAG_MAX'(up_tag);
                wr_ent.kind   = up_kind;
                wr_ent.target = upd_target_in[31:2];
                wr_ent.ctr    = CTR_T;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < ENTRIES; i++)
                btb[i] <= ENTRY_RST;
        end else if (wr_en) begin
            btb[up_idx] <= wr_ent;
        end
    end

    // ---------------- return address stack ----------------
`ifdef BP_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic                       spec_push, spec_pop, arch_push, arch_pop;
    logic [PTR_W-1:0]           arch_nxt_ptr, unused_spec_ptr;
    logic [PTR_W:0]             arch_nxt_cnt, unused_spec_cnt;
    logic [RAS_DEPTH-1:0][29:0] arch_nxt_mem, unused_spec_mem;
    logic [31:0]                unused_arch_top;
    logic                       unused_arch_empty;
    logic                       unused_lsbs;

    assign spec_push = lookup_valid_in && lk_hit && lk_ent.kind == CALL;
    assign spec_pop  = lookup_valid_in && lk_hit && lk_ent.kind == RET;
    assign arch_push = upd_valid_in && up_kind == CALL;
    assign arch_pop  = upd_valid_in && up_kind == RET;

    // On a flush the speculative copy takes the architectural state after this
    // cycle's push/pop. Its own push/pop in that cycle is dropped.
    bp_ras #(.DEPTH(RAS_DEPTH)) u_ras_spec (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (spec_push),
        .push_data (pc_in[31:2] + 30'd1),
        .pop       (spec_pop),
        .load      (upd_mispredict_in),
        .load_ptr  (arch_nxt_ptr),
        .load_cnt  (arch_nxt_cnt),
        .load_mem  (arch_nxt_mem),
        .nxt_ptr   (unused_spec_ptr),
        .nxt_cnt   (unused_spec_cnt),
        .nxt_mem   (unused_spec_mem),
        .top_out   (ras_top),
        .empty_out (ras_empty)
    );

    bp_ras #(.DEPTH(RAS_DEPTH)) u_ras_arch (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (arch_push),
        .push_data (upd_pc_in[31:2] + 30'd1),
        .pop       (arch_pop),
        .load      (1'b0),
        .load_ptr  ('0),
        .load_cnt  ('0),
        .load_mem  ('0),
        .nxt_ptr   (arch_nxt_ptr),
        .nxt_cnt   (arch_nxt_cnt),
        .nxt_mem   (arch_nxt_mem),
        .top_out   (unused_arch_top),
        .empty_out (unused_arch_empty)
    );

    assign unused_lsbs = ^{upd_pc_in[1:0], upd_target_in[1:0]};
`else
    logic unused_inputs;

    assign ras_top       = '0;
    assign ras_empty     = 1'b1;
    assign unused_inputs = ^{lookup_valid_in, upd_mispredict_in, upd_pc_in,
                             upd_target_in[1:0]};
`endif

endmodule
